// File: rtl/cpu_trace_buf_if.sv
// ---------------------------------------------------------------------------
// cpu_trace_buf_if
// Bundles every non-clock signal of the instruction-trace buffer.
//   Control  : arm, stop, trig_en, trig_pc        (host -> buffer)
//   Capture  : pc, inst, aluout                    (CPU  -> buffer)
//   Read port: rd_ready (host -> buffer), rd_valid, rd_pc, rd_inst, rd_alu
//   Status   : state, count, overflow              (buffer -> host)
// master = debug host / CPU side, slave = the trace buffer.
// ---------------------------------------------------------------------------
interface cpu_trace_buf_if #(
    parameter int AW = 4
);
    logic        arm;
    logic        stop;
    logic        trig_en;
    logic [31:0] trig_pc;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] aluout;
    logic        rd_ready;
    logic        rd_valid;
    logic [31:0] rd_pc;
    logic [31:0] rd_inst;
    logic [31:0] rd_alu;
    logic [1:0]  state;
    logic [AW:0] count;
    logic        overflow;

    modport master (
        output arm, stop, trig_en, trig_pc, pc, inst, aluout, rd_ready,
        input  rd_valid, rd_pc, rd_inst, rd_alu, state, count, overflow
    );

    modport slave (
        input  arm, stop, trig_en, trig_pc, pc, inst, aluout, rd_ready,
        output rd_valid, rd_pc, rd_inst, rd_alu, state, count, overflow
    );
endinterface

// File: rtl/cpu_trace_buf.sv
// ---------------------------------------------------------------------------
// cpu_trace_buf
// Circular instruction-trace buffer sampling {pc, inst, aluout} once per
// retired instruction. Capture starts on arm, ends on a PC-match trigger
// plus POST further entries, or on stop. Afterwards the host drains the
// trace oldest-first through a show-ahead valid/ready port.
// Ports:
//   clock : CPU clock
//   reset : synchronous, active-low reset
//   bus   : cpu_trace_buf_if slave modport (control, capture, read, status)
// ---------------------------------------------------------------------------
module cpu_trace_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int POST  = 4
) (
    input logic            clock,
    input logic            reset,
    cpu_trace_buf_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [AW:0]   FULL_C = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] POST_C = AW'(POST);

    state_e        state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [AW-1:0] post_q, post_d;
    logic          rd_valid_q, rd_valid_d;

    logic          wr_en_s;
    logic [95:0]   wr_data_s;
    logic [95:0]   mem_q [DEPTH];

    // Next-state, pointer and write-enable logic.
    always_comb begin
        state_d   = state_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        post_d    = post_q;
        wr_en_s   = 1'b0;
        wr_data_s = {bus.pc, bus.inst, bus.aluout};

        if (bus.arm) begin
            // arm wins over everything but reset; any read handshake is dropped
            state_d = ST_ARMED;
            wptr_d  = {AW{1'b0}};
            rptr_d  = {AW{1'b0}};
            count_d = {(AW+1){1'b0}};
            ovf_d   = 1'b0;
            post_d  = {AW{1'b0}};
        end else begin
            case (state_q)
                ST_ARMED, ST_POST: begin
                    wr_en_s = 1'b1;
                    wptr_d  = wptr_q + AW'(1);
                    // Full buffer: the oldest unread entry is dropped
                    if (count_q == FULL_C) begin
                        rptr_d = rptr_q + AW'(1);
                        ovf_d  = 1'b1;
                    end else begin
                        count_d = count_q + (AW+1)'(1);
                    end

                    if (bus.stop) begin
                        state_d = ST_DONE;
                    end else if (state_q == ST_ARMED) begin
                        if (bus.trig_en && (bus.pc == bus.trig_pc)) begin
                            if (POST_C == {AW{1'b0}}) begin
                                state_d = ST_DONE;
                            end else begin
                                post_d  = POST_C;
                                state_d = ST_POST;
                            end
                        end else begin
                            state_d = ST_ARMED;
                        end
                    end else begin
                        // Post window: this write is the last when counter is 1
                        post_d = post_q - AW'(1);
                        if (post_q == AW'(1)) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_POST;
                        end
                    end
                end
                ST_DONE: begin
                    if ((count_q != {(AW+1){1'b0}}) && bus.rd_ready) begin
                        rptr_d  = rptr_q + AW'(1);
                        count_d = count_q - (AW+1)'(1);
                    end else begin
                        rptr_d  = rptr_q;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end

        rd_valid_d = (state_d == ST_DONE) && (count_d != {(AW+1){1'b0}});
    end

    // Control and status registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            wptr_q     <= {AW{1'b0}};
            rptr_q     <= {AW{1'b0}};
            count_q    <= {(AW+1){1'b0}};
            ovf_q      <= 1'b0;
            post_q     <= {AW{1'b0}};
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            post_q     <= post_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Trace storage; contents are meaningless until written after arm.
    always_ff @(posedge clock) begin
        if (wr_en_s) begin
            mem_q[wptr_q] <= wr_data_s;
        end
    end

    assign bus.state    = state_q;
    assign bus.count    = count_q;
    assign bus.overflow = ovf_q;
    assign bus.rd_valid = rd_valid_q;
    // Show-ahead: oldest entry is visible without waiting for a pop
    assign bus.rd_pc    = mem_q[rptr_q][95:64];
    assign bus.rd_inst  = mem_q[rptr_q][63:32];
    assign bus.rd_alu   = mem_q[rptr_q][31:0];
endmodule

// File: tb/tb_cpu_trace_buf.sv
// ---------------------------------------------------------------------------
// tb_cpu_trace_buf
// Drives a POST=4 buffer (checked every cycle against a queue-based model and
// by directed literals) and a POST=0 buffer (directed literals only) from the
// same stimulus.
// ---------------------------------------------------------------------------
module tb_cpu_trace_buf;
    localparam int DEPTH  = 16;
    localparam int M_POST = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] alu;
    } ent_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        arm, stop, trig_en, rd_ready;
    logic [31:0] trig_pc, pc, inst, aluout;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Reference model state
    ent_t mq[$];
    int   m_state;
    bit   m_ovf;
    int   m_post;

    cpu_trace_buf_if #(.AW(4)) bus0 ();
    cpu_trace_buf_if #(.AW(4)) bus1 ();

    assign bus0.arm = arm;       assign bus1.arm = arm;
    assign bus0.stop = stop;     assign bus1.stop = stop;
    assign bus0.trig_en = trig_en; assign bus1.trig_en = trig_en;
    assign bus0.trig_pc = trig_pc; assign bus1.trig_pc = trig_pc;
    assign bus0.pc = pc;         assign bus1.pc = pc;
    assign bus0.inst = inst;     assign bus1.inst = inst;
    assign bus0.aluout = aluout; assign bus1.aluout = aluout;
    assign bus0.rd_ready = rd_ready; assign bus1.rd_ready = rd_ready;

    cpu_trace_buf #(.DEPTH(16), .AW(4), .POST(4)) u_dut (
        .clock(clock), .reset(reset), .bus(bus0.slave));
    cpu_trace_buf #(.DEPTH(16), .AW(4), .POST(0)) u_dut0 (
        .clock(clock), .reset(reset), .bus(bus1.slave));

    always #5 clock = ~clock;

    function automatic logic [31:0] f_inst(input logic [31:0] p);
        return p ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] f_alu(input logic [31:0] p);
        return (p * 32'd3) + 32'd7;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [31:0] p);
        pc     = p;
        inst   = f_inst(p);
        aluout = f_alu(p);
    endtask

    // Model: a FIFO of captured samples, updated from the rules at each edge.
    always @(posedge clock) begin
        if (!reset) begin
            m_state = 0; mq.delete(); m_ovf = 1'b0; m_post = 0;
        end else if (arm) begin
            m_state = 1; mq.delete(); m_ovf = 1'b0; m_post = 0;
        end else if (m_state == 1 || m_state == 2) begin
            mq.push_back('{pc, inst, aluout});
            if (mq.size() > DEPTH) begin
                void'(mq.pop_front());
                m_ovf = 1'b1;
            end
            if (stop) m_state = 3;
            else if (m_state == 1) begin
                if (trig_en && pc == trig_pc) begin
                    if (M_POST == 0) m_state = 3;
                    else begin m_post = M_POST; m_state = 2; end
                end
            end else begin
                m_post--;
                if (m_post == 0) m_state = 3;
            end
        end else if (m_state == 3) begin
            if (mq.size() > 0 && rd_ready) void'(mq.pop_front());
        end
    end

    // Every-cycle comparison of the POST=4 instance against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            chk("state", 32'(bus0.state), 32'(m_state));
            chk("count", 32'(bus0.count), 32'(mq.size()));
            chk("overflow", 32'(bus0.overflow), 32'(m_ovf));
            chk("rd_valid", 32'(bus0.rd_valid), 32'((m_state == 3) && (mq.size() > 0)));
            if (m_state == 3 && mq.size() > 0) begin
                chk("rd_pc", bus0.rd_pc, mq[0].pc);
                chk("rd_inst", bus0.rd_inst, mq[0].inst);
                chk("rd_alu", bus0.rd_alu, mq[0].alu);
            end
        end
    end

    initial begin
        int rdy_seq [4] = '{1, 0, 1, 1};
        int cnt_seq [4] = '{2, 2, 1, 0};
        bit done;
        int last_k;

        reset = 1'b0; arm = 1'b1; stop = 1'b0; trig_en = 1'b0; rd_ready = 1'b0;
        trig_pc = 32'h0; drive(32'h0);

        // Reset held for two cycles with arm asserted
        tick(); tick();
        reset = 1'b1; arm = 1'b0;
        chk_en = 1'b1;
        tick();
        chk("rst_state", 32'(bus0.state), 32'd0);
        chk("rst_count", 32'(bus0.count), 32'd0);
        chk("rst_ovf", 32'(bus0.overflow), 32'd0);
        chk("rst_valid", 32'(bus0.rd_valid), 32'd0);

        // Basic trigger at pc 0x14, four post entries
        arm = 1'b1; tick(); arm = 1'b0;
        trig_en = 1'b1; trig_pc = 32'h14;
        done = 1'b0; last_k = -1;
        for (int k = 0; k < 40 && !done; k++) begin
            drive(32'(k * 4)); tick();
            if (bus0.state == 2'd3) begin done = 1'b1; last_k = k; end
        end
        chk("trig_done_reached", 32'(done), 32'd1);
        chk("trig_last_pc", 32'(last_k * 4), 32'h24);
        chk("trig_count", 32'(bus0.count), 32'd10);
        trig_en = 1'b0; rd_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("trig_read_pc", bus0.rd_pc, 32'(i * 4));
            tick();
        end
        chk("trig_drained", 32'(bus0.rd_valid), 32'd0);
        rd_ready = 1'b0;

        // Wrap and overflow: 20 samples, stop on the 21st
        arm = 1'b1; tick(); arm = 1'b0;
        for (int k = 0; k < 20; k++) begin drive(32'(k * 4)); tick(); end
        drive(32'h50); stop = 1'b1; tick(); stop = 1'b0;
        chk("wrap_count", 32'(bus0.count), 32'd16);
        chk("wrap_ovf", 32'(bus0.overflow), 32'd1);
        chk("wrap_first_pc", bus0.rd_pc, 32'h14);
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("wrap_last_pc", bus0.rd_pc, 32'h50);
            tick();
        end
        rd_ready = 1'b0;

        // Backpressure with three stored entries
        arm = 1'b1; tick(); arm = 1'b0;
        drive(32'h500); tick();
        drive(32'h504); tick();
        drive(32'h508); stop = 1'b1; tick(); stop = 1'b0;
        chk("bp_count0", 32'(bus0.count), 32'd3);
        chk("bp_pc0", bus0.rd_pc, 32'h500);
        for (int i = 0; i < 4; i++) begin
            rd_ready = rdy_seq[i][0];
            tick();
            chk("bp_count", 32'(bus0.count), 32'(cnt_seq[i]));
            if (i == 1) chk("bp_hold_pc", bus0.rd_pc, 32'h504);
        end
        rd_ready = 1'b0;

        // POST=0 instance: match on the first sample
        arm = 1'b1; tick(); arm = 1'b0;
        trig_en = 1'b1; trig_pc = 32'h100;
        drive(32'h100); tick();
        chk("post0_state", 32'(bus1.state), 32'd3);
        chk("post0_count", 32'(bus1.count), 32'd1);

        // stop in the same cycle as a match wins over the post window
        arm = 1'b1; tick(); arm = 1'b0;
        trig_pc = 32'h208;
        drive(32'h200); tick();
        drive(32'h204); tick();
        chk("stop_pre_count", 32'(bus0.count), 32'd2);
        drive(32'h208); stop = 1'b1; tick(); stop = 1'b0;
        chk("stop_state", 32'(bus0.state), 32'd3);
        chk("stop_count", 32'(bus0.count), 32'd3);

        // Re-arm during the post window with seven entries stored
        arm = 1'b1; tick(); arm = 1'b0;
        trig_pc = 32'h300;
        for (int k = 0; k < 7; k++) begin drive(32'h2F4 + 32'(k * 4)); tick(); end
        chk("rearm_pre_state", 32'(bus0.state), 32'd2);
        chk("rearm_pre_count", 32'(bus0.count), 32'd7);
        arm = 1'b1; drive(32'h310); tick(); arm = 1'b0;
        chk("rearm_state", 32'(bus0.state), 32'd1);
        chk("rearm_count", 32'(bus0.count), 32'd0);
        chk("rearm_ovf", 32'(bus0.overflow), 32'd0);
        trig_en = 1'b0;
        drive(32'h400); tick();
        drive(32'h404); stop = 1'b1; tick(); stop = 1'b0;
        chk("rearm_new_count", 32'(bus0.count), 32'd2);
        chk("rearm_first_pc", bus0.rd_pc, 32'h400);

        tick(); tick();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cpu_trace_buf.md
Name: cpu_trace_buf

Overview:
- Instruction-trace capture buffer that sits directly downstream of the single-cycle CPU top.
- Samples that block's pc, inst and aluout outputs once per clock, i.e. once per retired instruction.
- Stores samples in a circular buffer with a PC-match trigger and a post-trigger window.
- After capture stops, a debug host drains the stored trace through a valid/ready read port.

Parameters:
- DEPTH, 16: number of trace entries; must be a power of two, minimum 2.
- AW, 4: pointer width; equals log2(DEPTH).
- POST, 4: entries captured after the trigger entry; range 0..DEPTH-1.

Ports:
- clock  in  1: CPU clock (same clock as the CPU core).
- reset  in  1: synchronous, active-low reset.
- arm  in  1: one-cycle pulse; clears the buffer and starts capture.
- stop  in  1: forces capture to end.
- trig_en  in  1: enables the PC-match trigger.
- trig_pc  in  32: trigger PC value.
- pc  in  32: CPU pc output.
- inst  in  32: CPU inst output.
- aluout  in  32: CPU aluout output.
- rd_ready  in  1: host accepts the current entry.
- rd_valid  out  1: an entry is available to read.
- rd_pc  out  32: oldest stored pc.
- rd_inst  out  32: oldest stored inst.
- rd_alu  out  32: oldest stored aluout.
- state  out  2: 0 IDLE, 1 ARMED, 2 POST, 3 DONE.
- count  out  AW+1: number of stored entries, 0..DEPTH.
- overflow  out  1: sticky; set when an unread entry was overwritten.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE, count=0, write and read pointers=0, overflow=0, post counter=0.
  - rd_valid=0.
  - rd_* are don't-care while rd_valid=0; the bench must not check them.
- All state updates happen on the rising edge of clock.
- Reset has the highest priority; arm is next.
- arm=1 in any state: clear pointers, count and overflow; next state=ARMED.
  - No sample is written in the arm cycle.
  - A read handshake in the same cycle is discarded.
- IDLE: no capture. rd_valid=0.
- ARMED:
  - Every cycle, write {pc,inst,aluout} at the write pointer and advance it (wraps modulo DEPTH).
  - If count<DEPTH: count increments.
  - If count==DEPTH: the read pointer also advances (oldest entry dropped), count stays DEPTH, overflow<=1.
  - If trig_en && pc==trig_pc: that cycle's sample is written and becomes the trigger entry.
    - POST==0: next state=DONE.
    - POST>0: post counter<=POST, next state=POST.
  - With trig_en=0, the buffer stays in ARMED indefinitely, running as a circular buffer.
- POST:
  - Writes every cycle with the same full/overwrite rules as ARMED.
  - The post counter decrements on each write.
  - The write made with post counter==1 is the last one; next state=DONE.
  - Further PC matches are ignored.
- stop=1 in ARMED or POST:
  - That cycle's sample is still written.
  - Next state=DONE.
  - stop takes priority over trigger handling.
  - stop is ignored in IDLE and DONE.
- DONE:
  - No writes.
  - rd_valid = (count!=0).
  - rd_* show the entry at the read pointer combinationally (show-ahead), oldest first.
  - When rd_valid && rd_ready: advance the read pointer (wrapping) and decrement count.
  - At count==0 the block stays in DONE with rd_valid=0 until arm.
- In ARMED and POST, rd_valid=0 and rd_ready is ignored.
- Comparison is an exact 32-bit equality.

Test Plan:
- Reset:
  - Stimulus: reset=0 for 2 cycles while arm=1.
  - Required: state=0, count=0, overflow=0, rd_valid=0 after release.
- Basic trigger, DEPTH=16, POST=4:
  - Stimulus: arm, then pc=0,4,8,... with trig_en=1, trig_pc=0x14.
  - Required: DONE is reached after the write with pc=0x24; count=10.
  - Required readout: pc 0x00..0x24 in order, inst/aluout match the driven values, then rd_valid=0.
- Wrap/overflow:
  - Stimulus: arm, trig_en=0, drive 20 samples pc=0..0x4C, then stop on the 21st (pc=0x50).
  - Required: count=16, overflow=1, readout starts at pc=0x14 and ends at 0x50.
- Backpressure:
  - Stimulus: in DONE with 3 entries, toggle rd_ready 1,0,1,1.
  - Required: rd_* hold stable while rd_ready=0; exactly 3 pops occur; count goes 3,2,2,1,0.
- POST=0 and stop priority:
  - Stimulus: with POST=0, a match on the first sample.
  - Required: count=1, DONE.
  - Stimulus: assert stop in the same cycle as a match with POST=4.
  - Required: DONE next cycle, count increased by 1.
- Re-arm mid-operation:
  - Stimulus: arm during POST with count=7.
  - Required: count=0, overflow=0, state=ARMED the next cycle; capture restarts from pointer 0.
